// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge instruction FIFO: entry-type tags,
// output-stage state encoding, default width/depth.
package bridge_pkg;

  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_DEPTH       = 8;

  localparam logic ENTRY_INSTR = 1'b0;
  localparam logic ENTRY_ADDR  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    SHOW_INSTR = 2'd1,
    SHOW_ADDR  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/bridge_instr_fifo_if.sv
// Producer/consumer bus of the bridge instruction FIFO: push strobes on the
// write side, level valids with one-cycle acknowledges on the read side.
interface bridge_instr_fifo_if #(
  parameter int W = 32
);

  // Write side: push_instr_i / push_addr_i are single-cycle strobes qualifying
  // wdata_i. Read side: a valid stays high holding its data until the consumer
  // pulses the acknowledge of the same type for one cycle.
  logic         push_instr_i;
  logic         push_addr_i;
  logic [W-1:0] wdata_i;
  logic         instr_valid_o;
  logic [W-1:0] instruction_o;
  logic         addr_valid_o;
  logic [W-1:0] new_section_address_o;
  logic         rst_instr_valid_i;
  logic         rst_new_address_valid_i;

  modport slave (
    input  push_instr_i, push_addr_i, wdata_i,
    input  rst_instr_valid_i, rst_new_address_valid_i,
    output instr_valid_o, instruction_o, addr_valid_o, new_section_address_o
  );

  modport master (
    output push_instr_i, push_addr_i, wdata_i,
    output rst_instr_valid_i, rst_new_address_valid_i,
    input  instr_valid_o, instruction_o, addr_valid_o, new_section_address_o
  );

endinterface

// File: rtl/bridge_fifo_mem.sv
// Storage for the bridge FIFO: pDEPTH x pWIDTH register array with wrapping
// read/write pointers and an occupancy counter. Caller never writes when full.
module bridge_fifo_mem #(
  parameter int pWIDTH = 33,
  parameter int pDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      wr_en_i,
  input  logic [pWIDTH-1:0]         wr_data_i,
  input  logic                      rd_en_i,
  output logic [pWIDTH-1:0]         rd_data_o,
  output logic [$clog2(pDEPTH):0]   level_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign full_o    = (level_q == LW'(pDEPTH));
  assign empty_o   = (level_q == '0);

endmodule

// File: rtl/bridge_instr_fifo.sv
// Bridge instruction FIFO: ordered queue of instruction / section-address words
// with a one-entry presentation stage. Optional push counter: BRIDGE_FIFO_STATS_EN.
module bridge_instr_fifo
  import bridge_pkg::*;
#(
  parameter int pINSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int pDEPTH       = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bridge_instr_fifo_if.slave       bus,
  input  logic                     flush_i,
  input  logic                     err_clr_i,
  output logic [$clog2(pDEPTH):0]  level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic                     protocol_err_o,
  output bridge_state_e            state_dbg_o
`ifdef BRIDGE_FIFO_STATS_EN
  ,
  output logic [15:0]              push_count_o
`endif
);

  localparam int EW = pINSTR_WIDTH + 1;

  bridge_state_e            state_q;
  bridge_state_e            state_nxt;
  logic [pINSTR_WIDTH-1:0]  out_q;
  logic [EW-1:0]            rd_entry;
  logic [EW-1:0]            wr_entry;
  logic                     push_one;
  logic                     push_both;
  logic                     push_ok;
  logic                     pop;
  logic                     ack_err;
  logic                     overflow_q;
  logic                     protocol_err_q;

  assign push_one  = bus.push_instr_i ^ bus.push_addr_i;
  assign push_both = bus.push_instr_i & bus.push_addr_i;
  // Full is judged before any same-cycle pop, so a push at full is always lost.
  assign push_ok   = push_one && !full_o && !flush_i;
  assign pop       = (state_q == EMPTY) && !empty_o && !flush_i;
  assign wr_entry  = {(bus.push_addr_i ? ENTRY_ADDR : ENTRY_INSTR), bus.wdata_i};

  bridge_fifo_mem #(
    .pWIDTH (EW),
    .pDEPTH (pDEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .wr_en_i   (push_ok),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .level_o   (level_o),
    .full_o    (full_o),
    .empty_o   (empty_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    ack_err   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.rst_instr_valid_i || bus.rst_new_address_valid_i) ack_err = 1'b1;
        if (pop) state_nxt = (rd_entry[EW-1] == ENTRY_ADDR) ? SHOW_ADDR : SHOW_INSTR;
      end
      SHOW_INSTR: begin
        if (bus.rst_new_address_valid_i) ack_err = 1'b1;
        if (bus.rst_instr_valid_i)       state_nxt = EMPTY;
      end
      SHOW_ADDR: begin
        if (bus.rst_instr_valid_i)       ack_err = 1'b1;
        if (bus.rst_new_address_valid_i) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush_i) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_q <= '0;
    else if (pop) out_q <= rd_entry[pINSTR_WIDTH-1:0];
  end

  // Clear wins over any set raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else if (err_clr_i) begin
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (push_one && full_o && !flush_i) overflow_q     <= 1'b1;
      if (push_both || ack_err)           protocol_err_q <= 1'b1;
    end
  end

`ifdef BRIDGE_FIFO_STATS_EN
  logic [15:0] push_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         push_count_q <= '0;
    else if (err_clr_i) push_count_q <= '0;
    else if (push_ok)   push_count_q <= push_count_q + 16'd1;
  end

  assign push_count_o = push_count_q;
`endif

  assign bus.instr_valid_o         = (state_q == SHOW_INSTR);
  assign bus.addr_valid_o          = (state_q == SHOW_ADDR);
  assign bus.instruction_o         = out_q;
  assign bus.new_section_address_o = out_q;
  assign overflow_o                = overflow_q;
  assign protocol_err_o            = protocol_err_q;
  assign state_dbg_o               = state_q;

endmodule

// File: tb/tb_bridge_instr_fifo.sv
// Bench for bridge_instr_fifo: directed scenarios with literal expectations,
// then random traffic checked every cycle against a queue-based model.
module tb_bridge_instr_fifo;
  import bridge_pkg::*;

  localparam int W = 32;
  localparam int D = 8;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          err_clr_i;
  logic [3:0]    level_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic          protocol_err_o;
  bridge_state_e state_dbg_o;

  bridge_instr_fifo_if #(.W(W)) bus ();

  bridge_instr_fifo #(
    .pINSTR_WIDTH (W),
    .pDEPTH       (D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush_i        (flush_i),
    .err_clr_i      (err_clr_i),
    .level_o        (level_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // exp_q holds {is_addr, word}; m_show: 0 nothing presented, 1 instr, 2 addr.
  logic [W:0]   exp_q[$];
  int           m_show;
  logic [W-1:0] m_word;
  logic         m_ov;
  logic         m_perr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_show = 0;
      m_word = '0;
      m_ov   = 1'b0;
      m_perr = 1'b0;
    end else begin
      logic pi, pa, ai, aa, fl, ec, was_full, bad_ack, one;
      logic [W:0] e;
      pi = bus.push_instr_i; pa = bus.push_addr_i;
      ai = bus.rst_instr_valid_i; aa = bus.rst_new_address_valid_i;
      fl = flush_i; ec = err_clr_i;
      one      = pi ^ pa;
      was_full = (exp_q.size() == D);
      bad_ack  = (ai && m_show != 1) || (aa && m_show != 2);
      if (fl) begin
        exp_q.delete();
        m_show = 0;
      end else begin
        if ((m_show == 1 && ai) || (m_show == 2 && aa)) m_show = 0;
        else if (m_show == 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          m_show = e[W] ? 2 : 1;
          m_word = e[W-1:0];
        end
        if (one && !was_full) exp_q.push_back({pa, bus.wdata_i});
      end
      if (ec) begin
        m_ov   = 1'b0;
        m_perr = 1'b0;
      end else begin
        if (one && was_full && !fl) m_ov = 1'b1;
        if ((pi && pa) || bad_ack)  m_perr = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("level", 64'(level_o), 64'(exp_q.size()));
    chk("full", 64'(full_o), 64'(exp_q.size() == D));
    chk("empty", 64'(empty_o), 64'(exp_q.size() == 0));
    chk("instr_valid", 64'(bus.instr_valid_o), 64'(m_show == 1));
    chk("addr_valid", 64'(bus.addr_valid_o), 64'(m_show == 2));
    chk("state", 64'(state_dbg_o),
        64'(m_show == 1 ? SHOW_INSTR : (m_show == 2 ? SHOW_ADDR : EMPTY)));
    chk("overflow", 64'(overflow_o), 64'(m_ov));
    chk("protocol_err", 64'(protocol_err_o), 64'(m_perr));
    if (m_show != 0) begin
      chk("instruction", 64'(bus.instruction_o), 64'(m_word));
      chk("section_addr", 64'(bus.new_section_address_o), 64'(m_word));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic pi, input logic pa, input logic [W-1:0] wd,
                      input logic ai, input logic aa, input logic fl, input logic ec);
    bus.push_instr_i            = pi;
    bus.push_addr_i             = pa;
    bus.wdata_i                 = wd;
    bus.rst_instr_valid_i       = ai;
    bus.rst_new_address_valid_i = aa;
    flush_i                     = fl;
    err_clr_i                   = ec;
    @(posedge clk);
    #1;
    bus.push_instr_i            = 1'b0;
    bus.push_addr_i             = 1'b0;
    bus.rst_instr_valid_i       = 1'b0;
    bus.rst_new_address_valid_i = 1'b0;
    flush_i                     = 1'b0;
    err_clr_i                   = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_i(input logic [W-1:0] wd);
    step(1'b1, 1'b0, wd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_a(input logic [W-1:0] wd);
    step(1'b0, 1'b1, wd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.push_instr_i = 1'b0; bus.push_addr_i = 1'b0; bus.wdata_i = '0;
    bus.rst_instr_valid_i = 1'b0; bus.rst_new_address_valid_i = 1'b0;
    flush_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_valids", 64'({bus.instr_valid_o, bus.addr_valid_o}), 64'd0);
    rst_n = 1'b1;
    idle();

    // single instruction, two-edge latency
    push_i(32'h0000_0013);
    chk("lat_level1", 64'(level_o), 64'd1);
    chk("lat_not_yet", 64'(bus.instr_valid_o), 64'd0);
    idle();
    chk("lat_valid", 64'(bus.instr_valid_o), 64'd1);
    chk("lat_data", 64'(bus.instruction_o), 64'h13);
    chk("lat_level0", 64'(level_o), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ack_clears", 64'(bus.instr_valid_o), 64'd0);

    // ordering across types
    push_a(32'h0000_0180);
    push_i(32'h0010_0093);
    idle(); idle();
    chk("ord_addr_valid", 64'(bus.addr_valid_o), 64'd1);
    chk("ord_addr_data", 64'(bus.new_section_address_o), 64'h180);
    chk("ord_instr_hidden", 64'(bus.instr_valid_o), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("ord_instr_valid", 64'(bus.instr_valid_o), 64'd1);
    chk("ord_instr_data", 64'(bus.instruction_o), 64'h0010_0093);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // overflow at depth 8 while the output stage is held
    push_i(32'hAAAA_0000);
    idle();
    for (int i = 1; i <= 9; i++) push_i(32'hAAAA_0000 + 32'(i));
    chk("ovf_level", 64'(level_o), 64'd8);
    chk("ovf_full", 64'(full_o), 64'd1);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    step(1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_level", 64'(level_o), 64'd0);
    chk("flush_valid", 64'(bus.instr_valid_o), 64'd0);
    chk("flush_keeps_ovf", 64'(overflow_o), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("errclr_ovf", 64'(overflow_o), 64'd0);

    // simultaneous pushes and mismatched acknowledge
    push_a(32'h0000_00A0);
    idle();
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_level", 64'(level_o), 64'd0);
    chk("both_perr", 64'(protocol_err_o), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("perr_cleared", 64'(protocol_err_o), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrong_ack_perr", 64'(protocol_err_o), 64'd1);
    chk("wrong_ack_hold", 64'(bus.addr_valid_o), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("errclr_prio", 64'(protocol_err_o), 64'd0);

    // flush with five stored entries and a same-cycle push
    for (int i = 0; i < 6; i++) push_i(32'h1000 + 32'(i));
    chk("fill5_level", 64'(level_o), 64'd5);
    step(1'b1, 1'b0, 32'h7777, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl5_level", 64'(level_o), 64'd0);
    chk("fl5_empty", 64'(empty_o), 64'd1);
    chk("fl5_valids", 64'({bus.instr_valid_o, bus.addr_valid_o}), 64'd0);
    chk("fl5_ovf", 64'(overflow_o), 64'd0);

    // reset mid-transfer
    for (int i = 0; i < 4; i++) push_i(32'h2000 + 32'(i));
    chk("mid_level3", 64'(level_o), 64'd3);
    chk("mid_showing", 64'(bus.instr_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.instr_valid_o), 64'd0);
    chk("mid_rst_data", 64'(bus.instruction_o), 64'd0);
    chk("mid_rst_level", 64'(level_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_i(32'h0000_0ABC);
    idle();
    chk("post_rst_valid", 64'(bus.instr_valid_o), 64'd1);
    chk("post_rst_data", 64'(bus.instruction_o), 64'hABC);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic pi, pa, ai, aa, fl, ec;
      r  = $urandom_range(0, 99);
      pi = (r < 30) || (r == 99);
      pa = (r >= 30 && r < 47) || (r == 99);
      ai = (m_show == 1) && ($urandom_range(0, 3) == 0);
      aa = (m_show == 2) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) ai = 1'b1;
      if ($urandom_range(0, 49) == 0) aa = 1'b1;
      fl = ($urandom_range(0, 79) == 0);
      ec = ($urandom_range(0, 39) == 0);
      step(pi, pa, 32'($urandom), ai, aa, fl, ec);
    end

    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
